booth2_pp_final_adder: RTL and testbench



---
 rtl/booth2_pkg.sv | 22 ++
 rtl/booth2_seg_add_stage.sv | 71 +++++++
 rtl/booth2_pp_final_adder.sv | 69 ++++++
 tb/tb_booth2_pp_final_adder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/booth2_pkg.sv
// Shared widths and helpers for the Booth radix-4 final carry-propagate adder.
package booth2_pkg;

    localparam int unsigned PROD_W        = 32;
    localparam int unsigned PP1_W         = 32;
    localparam int unsigned PP2_W         = 30;
    localparam int unsigned PP2_SHIFT     = 2;
    localparam int unsigned SEG_W_DEFAULT = 8;

    // Mask with ones in bit positions [lo, lo+w), clipped to PROD_W.
    function automatic logic [PROD_W-1:0] seg_mask(input int unsigned lo, input int unsigned w);
        logic [PROD_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < PROD_W; i++) begin
            if ((i >= lo) && (i < lo + w)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/booth2_seg_add_stage.sv
// One SEG_W-bit slice of the segmented final adder, with its pipeline registers.
// Bits [LO +: SEG_W] of A and B are added together with the incoming carry.
// The sum vector keeps every segment produced so far; A and B keep only the
// bits that later stages still have to add (processed bits are cleared).
module booth2_seg_add_stage
    import booth2_pkg::*;
#(
    parameter int unsigned SEG_W = SEG_W_DEFAULT,
    parameter int unsigned LO    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic              v_i,
    input  logic              c_i,
    input  logic [PROD_W-1:0] a_i,
    input  logic [PROD_W-1:0] b_i,
    input  logic [PROD_W-1:0] s_i,
    output logic              v_o,
    output logic              c_o,
    output logic [PROD_W-1:0] a_o,
    output logic [PROD_W-1:0] b_o,
    output logic [PROD_W-1:0] s_o
);

    localparam logic [PROD_W-1:0] SEG_MASK  = seg_mask(LO, SEG_W);
    localparam logic [PROD_W-1:0] DONE_MASK = seg_mask(0, LO + SEG_W);

    logic [SEG_W:0]    seg_sum;
    logic              v_q, v_d;
    logic              c_q, c_d;
    logic [PROD_W-1:0] a_q, a_d;
    logic [PROD_W-1:0] b_q, b_d;
    logic [PROD_W-1:0] s_q, s_d;

    // Segment add and next-state vectors for this slice.
    always_comb begin
        seg_sum = {1'b0, a_i[LO +: SEG_W]}
                + {1'b0, b_i[LO +: SEG_W]}
                + {{SEG_W{1'b0}}, c_i};
        v_d = v_i;
        c_d = seg_sum[SEG_W];
        a_d = a_i & ~DONE_MASK;
        b_d = b_i & ~DONE_MASK;
        s_d = (s_i & ~SEG_MASK) | (PROD_W'(seg_sum[SEG_W-1:0]) << LO);
    end

    // Pipeline registers: everything, including valid, holds while en_i is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
        end else if (en_i) begin
            v_q <= v_d;
            c_q <= c_d;
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
        end
    end

    assign v_o = v_q;
    assign c_o = c_q;
    assign a_o = a_q;
    assign b_o = b_q;
    assign s_o = s_q;

endmodule

// File: rtl/booth2_pp_final_adder.sv
// Final carry-propagate stage of the 16x16 Booth radix-4 multiplier.
// product = (in_pp1 + (in_pp2 << 2)) mod 2^32, computed by NSEG = 32/SEG_W
// pipelined segment adders so no full 32-bit ripple sits in a single cycle.
// Valid/ready on both sides; the whole pipeline stalls as one when the
// output is valid but not taken.
module booth2_pp_final_adder
    import booth2_pkg::*;
#(
    parameter int unsigned SEG_W = SEG_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PP1_W-1:0]  in_pp1,
    input  logic [PP2_W-1:0]  in_pp2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_product,
    output logic              out_cout
);

    localparam int unsigned NSEG = PROD_W / SEG_W;

    logic              en;
    logic              v_pipe [NSEG+1];
    logic              c_pipe [NSEG+1];
    logic [PROD_W-1:0] a_pipe [NSEG+1];
    logic [PROD_W-1:0] b_pipe [NSEG+1];
    logic [PROD_W-1:0] s_pipe [NSEG+1];

    // Global advance: blocked only by a valid output that is not being taken.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // Operand alignment into the first stage; vector 2 carries weight 2^2 at bit 0.
    assign v_pipe[0] = in_valid;
    assign c_pipe[0] = 1'b0;
    assign a_pipe[0] = in_pp1;
    assign b_pipe[0] = {in_pp2, {PP2_SHIFT{1'b0}}};
    assign s_pipe[0] = '0;

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        booth2_seg_add_stage #(
            .SEG_W (SEG_W),
            .LO    (k * SEG_W)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .en_i (en),
            .v_i  (v_pipe[k]),
            .c_i  (c_pipe[k]),
            .a_i  (a_pipe[k]),
            .b_i  (b_pipe[k]),
            .s_i  (s_pipe[k]),
            .v_o  (v_pipe[k+1]),
            .c_o  (c_pipe[k+1]),
            .a_o  (a_pipe[k+1]),
            .b_o  (b_pipe[k+1]),
            .s_o  (s_pipe[k+1])
        );
    end

    // Outputs come straight from the final-stage registers.
    assign out_valid   = v_pipe[NSEG];
    assign out_product = s_pipe[NSEG];
    assign out_cout    = c_pipe[NSEG];

endmodule

// File: tb/tb_booth2_pp_final_adder.sv
// Scoreboard bench for booth2_pp_final_adder: the driver pushes the expected
// product per accepted beat, a negedge monitor pops and compares on transfer.
module tb_booth2_pp_final_adder;
    import booth2_pkg::*;

    localparam int unsigned SEG_W = 8;
    localparam int unsigned NSEG  = PROD_W / SEG_W;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pp1;
    logic [29:0] in_pp2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_product;
    logic        out_cout;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] prod;
        logic        cout;
        int          acc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   chk_lat_mode = 1'b1;
    bit   stim_done;
    int   tries;

    booth2_pp_final_adder #(.SEG_W(SEG_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pp1      (in_pp1),
        .in_pp2      (in_pp2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .out_cout    (out_cout)
    );

    always #5 clk = ~clk;

    // Rising-edge counter; read at posedge+1 it equals the edge just taken.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one beat and hold it until accepted; push the reference result.
    task automatic beat(input logic [31:0] a, input logic [29:0] b, output int n_try);
        logic [32:0] full;
        bit          acc;
        exp_t        e;
        n_try    = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_pp1   = a;
        in_pp2   = b;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n_try++;
        end while (!acc && n_try < 50);
        in_valid = 1'b0;
        if (!acc) begin
            chk("accept_timeout", {31'b0, acc}, 32'd1);
        end else begin
            full      = {1'b0, a} + 33'(b) * 33'd4;
            e.prod    = full[31:0];
            e.cout    = full[32];
            e.acc     = cyc;
            e.chk_lat = chk_lat_mode;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: compare on every transfer; while stalled the held output must
    // already be the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", {31'b0, out_valid}, 32'd0);
            end else if (out_ready) begin
                mon_e = sb.pop_front();
                chk("product", out_product, mon_e.prod);
                chk("cout", {31'b0, out_cout}, {31'b0, mon_e.cout});
                // The accepting edge is the first of NSEG register stages.
                if (mon_e.chk_lat)
                    chk("latency", 32'(cyc - mon_e.acc), 32'(NSEG - 1));
            end else begin
                chk("stall_hold_product", out_product, sb[0].prod);
                chk("stall_hold_cout", {31'b0, out_cout}, {31'b0, sb[0].cout});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pp1    = '0;
        in_pp2    = '0;
        out_ready = 1'b1;
        #1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_product", out_product, 32'd0);
        chk("reset_cout", {31'b0, out_cout}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic sum and full-length carry ripple.
        beat(32'h0000_00FF, 30'h1, tries);
        drain();
        beat(32'hFFFF_FFFC, 30'h1, tries);
        beat(32'hFFFF_FFFF, 30'h0, tries);
        beat(32'h0000_0000, 30'h3FFF_FFFF, tries);
        drain();

        // Back-to-back random stream, no backpressure.
        for (int i = 0; i < 16; i++) begin
            beat($urandom, 30'($urandom), tries);
            chk("stream_in_ready", 32'(tries), 32'd1);
        end
        drain();

        // Backpressure: 5 stalled cycles mid-stream.
        chk_lat_mode = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) beat($urandom, 30'($urandom), tries);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk_lat_mode = 1'b1;

        // Bubbles: valid pattern 1,0,1,1,0.
        beat($urandom, 30'($urandom), tries);
        idle();
        beat($urandom, 30'($urandom), tries);
        beat($urandom, 30'($urandom), tries);
        idle();
        drain();

        // Random bubbles mixed with random backpressure.
        chk_lat_mode = 1'b0;
        stim_done    = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    if ($urandom_range(0, 3) == 0) idle();
                    beat($urandom, 30'($urandom), tries);
                end
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk_lat_mode = 1'b1;

        // Asynchronous reset with beats in flight and one on the output.
        for (int i = 0; i < 6; i++) beat($urandom, 30'($urandom), tries);
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("async_rst_product", out_product, 32'd0);
        chk("async_rst_cout", {31'b0, out_cout}, 32'd0);
        chk("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
        sb.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        beat(32'h1234_5678, 30'h0ABC_DEF0, tries);
        drain();
        repeat (NSEG + 3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
